mem_request_unit: RTL and testbench
===================================

Name: mem_request_unit

Overview:
- Sits between the single-cycle core and the word-addressed data/instruction RAM (32 x 32-bit words, combinational read, write on clock edge, busy handshake).
- Arbitrates one instruction fetch port and one data load/store port onto the single RAM port.
- Converts byte/halfword loads and stores into word accesses: sign/zero-extends loads, and does read-modify-write for sub-word stores.
- Flags misaligned and out-of-range accesses.

Parameters:
- RAM_WORDS, 32, number of 32-bit words in the RAM; byte addresses >= RAM_WORDS*4 are out of range.
- ADDR_W, 32, width of core-side byte addresses.

Ports:
- clk  in  1  clock
- nRst  in  1  asynchronous active-low reset
- i_req  in  1  instruction fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch byte address
- i_rdata  out  32  fetched instruction, valid with i_ack
- i_ack  out  1  one-cycle fetch completion pulse
- d_ren  in  1  load request, held until d_ack
- d_wen  in  1  store request, held until d_ack
- d_addr  in  ADDR_W  load/store byte address
- d_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- d_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
- d_wdata  in  32  store data, right-aligned
- d_rdata  out  32  extended load data, valid with d_ack
- d_ack  out  1  one-cycle data completion pulse
- d_err  out  1  with d_ack: misaligned or out-of-range, no RAM access made
- ram_addr  out  32  byte address to RAM, word-aligned (low 2 bits 0)
- ram_wen  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM combinational read data
- ram_busy  in  1  RAM not ready; no sample or write completes while high

Behaviour:
- Reset: state IDLE; i_ack, d_ack, d_err, ram_wen = 0; i_rdata, d_rdata, ram_addr, ram_wdata = 0.
- Reset mid-operation: abandons the access; no write is issued after nRst is asserted.
- FSM states: IDLE, IACC, DRD, DWR, DONE.
- IDLE:
  - data request (d_ren|d_wen) has priority over i_req.
  - d_ren and d_wen both high: treated as a store.
  - data request with error: to DONE with d_err=1 and d_rdata=0.
  - valid load, or sub-word store: to DRD.
  - valid word store: to DWR.
  - else if i_req: to IACC.
- Error conditions:
  - half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - addr >= RAM_WORDS*4 is out of range.
  - fetch errors are not flagged: fetch address is forced word-aligned and wraps modulo RAM_WORDS*4.
- IACC:
  - ram_addr = {i_addr[..2],2'b00}.
  - when !ram_busy: latch ram_rdata into i_rdata, go to DONE.
  - else stay in IACC.
- DRD:
  - ram_addr = aligned d_addr; waits while ram_busy.
  - Load: select byte lane addr[1:0] or half lane addr[1], extend per d_unsigned, latch into d_rdata, go to DONE.
  - Sub-word store: merge d_wdata low byte/half into the read word at that lane, latch into ram_wdata, go to DWR.
- DWR:
  - ram_addr aligned; ram_wen=1 only while !ram_busy; go to DONE in the cycle ram_wen is high with !ram_busy.
  - Word store: ram_wdata = d_wdata.
- DONE:
  - exactly one of i_ack/d_ack high for one cycle, then IDLE.
  - requests sampled again next cycle, so back-to-back requests of the same kind incur one IDLE cycle.
- Latency with ram_busy=0:
  - fetch and load: ack 2 cycles after the request is sampled in IDLE.
  - word store: ack 2 cycles after sampling.
  - sub-word store: ack 3 cycles after sampling.
  - error: ack 1 cycle after sampling.
- Request dropped before ack: the access still completes and the ack is still pulsed; this is a core protocol violation.
- Simultaneous i_req and d request: data is served first; the fetch follows because i_req stays held.
- Address, data and size are re-read from the inputs each cycle; they must be held stable while the request is pending.

Optional Feature:
- Macro: MEM_REQ_PERF_EN.
- Defined:
  - adds output perf_stall_cycles[31:0], counting cycles in IACC/DRD/DWR with ram_busy=1.
  - adds output perf_accesses[31:0], counting i_ack|d_ack pulses.
  - both counters wrap at 2^32 and reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package mem_req_pkg holds:
  - state enum mem_req_state_t;
  - size enum mem_size_t (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2);
  - lane-select and extend helper functions.
- One sub-module, mem_lane_align: purely combinational load extraction/extension and store merge, shared by DRD.

Test Plan:
- Word load at 0x08, mem[2]=0xDEADBEEF, busy=0 -> d_ack on cycle 2, d_rdata=0xDEADBEEF, d_err=0.
- Byte load signed at 0x0B, mem[2]=0x80FF1234 -> d_rdata=0xFFFFFF80; unsigned -> 0x00000080.
- Halfword store 0xABCD at 0x06, mem[1]=0x11223344 -> one ram_wen pulse, mem[1]=0xABCD3344, ack 3 cycles after sampling.
- Word load at 0x05, or at 0x80 with RAM_WORDS=32 -> d_ack with d_err=1, d_rdata=0, ram_wen never high.
- i_req and d_ren high together, ram_busy high 3 cycles in DRD -> d_ack first (stall cycles counted under MEM_REQ_PERF_EN), then i_ack 3 cycles later.
- nRst low while in DWR with ram_busy=1 -> ram_wen stays 0, all outputs 0, memory unchanged.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and lane helpers for the memory request unit.
package mem_req_pkg;

  typedef logic [2:0] mem_req_state_t;

  localparam mem_req_state_t IDLE = 3'd0;
  localparam mem_req_state_t IACC = 3'd1;
  localparam mem_req_state_t DRD  = 3'd2;
  localparam mem_req_state_t DWR  = 3'd3;
  localparam mem_req_state_t DONE = 3'd4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  // Size 2'b11 falls through to the word path in both helpers.
  function automatic logic [31:0] lane_load(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] size, input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    if (size == SZ_BYTE) begin
      return is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
    end else if (size == SZ_HALF) begin
      return is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
    end
    return word;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] m;
    m = word;
    if (size == SZ_BYTE) begin
      m[{lane, 3'b000} +: 8] = wdata[7:0];
    end else if (size == SZ_HALF) begin
      if (lane[1]) m[31:16] = wdata[15:0];
      else         m[15:0]  = wdata[15:0];
    end else begin
      m = wdata;
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational load extraction/extension and sub-word store merge.
module mem_lane_align
  import mem_req_pkg::*;
(
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  assign o_load  = lane_load(i_rword, i_lane, i_size, i_unsigned);
  assign o_merge = lane_merge(i_rword, i_wdata, i_lane, i_size);

endmodule

// File: rtl/mem_request_unit.sv
// Arbitrates fetch and data ports onto one word RAM port, with sub-word RMW.
// Optional MEM_REQ_PERF_EN adds stall and access counters.
module mem_request_unit
  import mem_req_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       ram_addr,
  output logic              ram_wen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_busy
`ifdef MEM_REQ_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_accesses
`endif
);

  localparam int unsigned RAM_BYTES = RAM_WORDS * 4;
  // RAM_WORDS is expected to be a power of two so fetch wrap is a bit slice.
  localparam int unsigned BYTE_AW   = $clog2(RAM_BYTES);

  mem_req_state_t r_state, w_state_next;
  logic           r_is_data, r_err;
  logic [31:0]    r_i_rdata, r_d_rdata, r_merge;

  logic        w_d_req, w_is_byte, w_is_half, w_sub, w_misalign, w_oor, w_err;
  logic [31:0] w_fetch_addr, w_data_addr, w_load, w_merge;
  logic        w_unused_iaddr;

  assign w_d_req    = d_ren | d_wen;
  assign w_is_byte  = (d_size == SZ_BYTE);
  assign w_is_half  = (d_size == SZ_HALF);
  assign w_sub      = w_is_byte | w_is_half;
  assign w_misalign = (w_is_half & d_addr[0]) | (~w_sub & (d_addr[1:0] != 2'b00));
  assign w_oor      = (d_addr >= ADDR_W'(RAM_BYTES));
  assign w_err      = w_misalign | w_oor;

  assign w_fetch_addr   = 32'({i_addr[BYTE_AW-1:2], 2'b00});
  assign w_data_addr    = 32'({d_addr[ADDR_W-1:2], 2'b00});
  assign w_unused_iaddr = ^{i_addr[ADDR_W-1:BYTE_AW], i_addr[1:0]};

  mem_lane_align u_lane_align (
    .i_rword    (ram_rdata),
    .i_wdata    (d_wdata),
    .i_lane     (d_addr[1:0]),
    .i_size     (d_size),
    .i_unsigned (d_unsigned),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_d_req) begin
          if (w_err)               w_state_next = DONE;
          else if (d_wen && !w_sub) w_state_next = DWR;
          else                     w_state_next = DRD;
        end else if (i_req) begin
          w_state_next = IACC;
        end
      end
      IACC:    if (!ram_busy) w_state_next = DONE;
      DRD:     if (!ram_busy) w_state_next = d_wen ? DWR : DONE;
      DWR:     if (!ram_busy) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= IDLE;
      r_is_data <= 1'b0;
      r_err     <= 1'b0;
      r_i_rdata <= 32'h0;
      r_d_rdata <= 32'h0;
      r_merge   <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE) begin
        if (w_d_req) begin
          r_is_data <= 1'b1;
          r_err     <= w_err;
          if (w_err) r_d_rdata <= 32'h0;
        end else if (i_req) begin
          r_is_data <= 1'b0;
          r_err     <= 1'b0;
        end
      end
      if (r_state == IACC && !ram_busy) r_i_rdata <= ram_rdata;
      if (r_state == DRD && !ram_busy) begin
        if (d_wen) r_merge   <= w_merge;
        else       r_d_rdata <= w_load;
      end
    end
  end

  always_comb begin
    ram_addr = 32'h0;
    case (r_state)
      IACC:     ram_addr = w_fetch_addr;
      DRD, DWR: ram_addr = w_data_addr;
      default:  ram_addr = 32'h0;
    endcase
  end

  assign ram_wen   = (r_state == DWR) & ~ram_busy;
  assign ram_wdata = (r_state == DWR) ? (w_sub ? r_merge : d_wdata) : 32'h0;

  assign i_ack   = (r_state == DONE) & ~r_is_data;
  assign d_ack   = (r_state == DONE) & r_is_data;
  assign d_err   = d_ack & r_err;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

`ifdef MEM_REQ_PERF_EN
  logic [31:0] r_stall_cnt, r_access_cnt;
  logic        w_in_access;

  assign w_in_access = (r_state == IACC) | (r_state == DRD) | (r_state == DWR);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_stall_cnt  <= 32'h0;
      r_access_cnt <= 32'h0;
    end else begin
      if (w_in_access && ram_busy) r_stall_cnt  <= r_stall_cnt + 32'd1;
      if (i_ack || d_ack)          r_access_cnt <= r_access_cnt + 32'd1;
    end
  end

  assign perf_stall_cycles = r_stall_cnt;
  assign perf_accesses     = r_access_cnt;
`endif

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit with a behavioural 32-word RAM.
module tb_mem_request_unit;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_ren = 1'b0;
  logic        d_wen = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [1:0]  d_size = 2'd0;
  logic        d_unsigned = 1'b0;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] ram_addr;
  logic        ram_wen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_busy = 1'b0;
`ifdef MEM_REQ_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_accesses;
`endif

  mem_request_unit u_dut (
    .clk        (clk),
    .nRst       (nRst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_ack      (i_ack),
    .d_ren      (d_ren),
    .d_wen      (d_wen),
    .d_addr     (d_addr),
    .d_size     (d_size),
    .d_unsigned (d_unsigned),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .d_err      (d_err),
    .ram_addr   (ram_addr),
    .ram_wen    (ram_wen),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_busy   (ram_busy)
`ifdef MEM_REQ_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_accesses     (perf_accesses)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  int          n_wen = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  assign ram_rdata = mem[ram_addr[6:2]];

  always @(negedge clk) begin
    if (ram_wen && !ram_busy) begin
      mem[ram_addr[6:2]] = ram_wdata;
      n_wen = n_wen + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic data_xfer(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                           output int cyc, output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    d_ren = ren; d_wen = wen; d_addr = addr; d_size = size; d_unsigned = uns; d_wdata = wdata;
    cyc = -1; rdata = 32'h0; err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (d_ack) begin
        cyc = k; rdata = d_rdata; err = d_err;
        break;
      end
    end
    d_ren = 1'b0; d_wen = 1'b0;
  endtask

  task automatic fetch_xfer(input logic [31:0] addr, output int cyc, output logic [31:0] rdata);
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = addr;
    cyc = -1; rdata = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (i_ack) begin
        cyc = k; rdata = i_rdata;
        break;
      end
    end
    i_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int          cyc, dack_c, iack_c, wen0;
  logic [31:0] rd, got_d, got_i, saved;
  logic        er;
`ifdef MEM_REQ_PERF_EN
  logic [31:0] stall0, acc0;
`endif

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[1] = 32'h11223344;
    mem[2] = 32'hDEADBEEF;
    mem[5] = 32'h13572468;

    #12;
    check("rst_ctrl", {28'h0, i_ack, d_ack, d_err, ram_wen}, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_rdata", i_rdata | d_rdata, 32'h0);
    @(negedge clk) nRst = 1'b1;

    data_xfer(1, 0, 32'h08, 2'd2, 0, 32'h0, cyc, rd, er);
    check("ld_word_lat", 32'(cyc), 32'd2);
    check("ld_word_data", rd, 32'hDEADBEEF);
    check("ld_word_err", {31'h0, er}, 32'h0);

    mem[2] = 32'h80FF1234;
    data_xfer(1, 0, 32'h0B, 2'd0, 0, 32'h0, cyc, rd, er);
    check("ld_byte_s", rd, 32'hFFFFFF80);
    data_xfer(1, 0, 32'h0B, 2'd0, 1, 32'h0, cyc, rd, er);
    check("ld_byte_u", rd, 32'h00000080);
    data_xfer(1, 0, 32'h0A, 2'd1, 0, 32'h0, cyc, rd, er);
    check("ld_half_s", rd, 32'hFFFF80FF);
    data_xfer(1, 0, 32'h08, 2'd1, 1, 32'h0, cyc, rd, er);
    check("ld_half_u", rd, 32'h00001234);

    wen0 = n_wen;
    data_xfer(0, 1, 32'h06, 2'd1, 0, 32'h0000ABCD, cyc, rd, er);
    check("st_half_lat", 32'(cyc), 32'd3);
    check("st_half_mem", mem[1], 32'hABCD3344);
    check("st_half_wen", 32'(n_wen - wen0), 32'd1);

    data_xfer(0, 1, 32'h01, 2'd0, 0, 32'hFFFFFF5A, cyc, rd, er);
    check("st_byte_lat", 32'(cyc), 32'd3);
    check("st_byte_mem", mem[0], 32'h00005A00);

    wen0 = n_wen;
    data_xfer(1, 1, 32'h0C, 2'd2, 0, 32'hCAFEF00D, cyc, rd, er);
    check("st_word_lat", 32'(cyc), 32'd2);
    check("st_word_mem", mem[3], 32'hCAFEF00D);
    check("st_word_wen", 32'(n_wen - wen0), 32'd1);

    wen0 = n_wen;
    data_xfer(1, 0, 32'h05, 2'd2, 0, 32'h0, cyc, rd, er);
    check("err_misal_lat", 32'(cyc), 32'd1);
    check("err_misal_flag", {31'h0, er}, 32'h1);
    check("err_misal_data", rd, 32'h0);
    data_xfer(1, 0, 32'h80, 2'd2, 0, 32'h0, cyc, rd, er);
    check("err_oor_flag", {31'h0, er}, 32'h1);
    data_xfer(0, 1, 32'h03, 2'd1, 0, 32'h0000FFFF, cyc, rd, er);
    check("err_st_half_flag", {31'h0, er}, 32'h1);
    data_xfer(1, 0, 32'h02, 2'd3, 0, 32'h0, cyc, rd, er);
    check("err_sz3_flag", {31'h0, er}, 32'h1);
    check("err_no_wen", 32'(n_wen - wen0), 32'd0);
    check("err_mem0", mem[0], 32'h00005A00);

    fetch_xfer(32'h08, cyc, rd);
    check("fetch_lat", 32'(cyc), 32'd2);
    check("fetch_data", rd, 32'h80FF1234);
    fetch_xfer(32'h8A, cyc, rd);
    check("fetch_wrap", rd, 32'h80FF1234);

    // Data and fetch together; RAM busy for three cycles while in DRD.
    @(posedge clk); #1;
    d_ren = 1'b1; d_addr = 32'h14; d_size = 2'd2; d_unsigned = 1'b0;
    i_req = 1'b1; i_addr = 32'h0C;
`ifdef MEM_REQ_PERF_EN
    stall0 = perf_stall_cycles;
    acc0   = perf_accesses;
`endif
    dack_c = -1; iack_c = -1; got_d = 32'h0; got_i = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1 ram_busy = (k <= 3);
      @(negedge clk);
      if (d_ack) begin dack_c = k; got_d = d_rdata; d_ren = 1'b0; end
      if (i_ack) begin iack_c = k; got_i = i_rdata; i_req = 1'b0; break; end
    end
    ram_busy = 1'b0; d_ren = 1'b0; i_req = 1'b0;
    check("arb_dack_cyc", 32'(dack_c), 32'd5);
    check("arb_iack_cyc", 32'(iack_c), 32'd8);
    check("arb_d_data", got_d, 32'h13572468);
    check("arb_i_data", got_i, 32'hCAFEF00D);
`ifdef MEM_REQ_PERF_EN
    check("perf_stall", perf_stall_cycles - stall0, 32'd3);
    check("perf_access", perf_accesses - acc0, 32'd2);
`endif

    // Reset while a word store is held off by a busy RAM.
    saved = mem[4];
    wen0  = n_wen;
    @(posedge clk); #1;
    d_wen = 1'b1; d_addr = 32'h10; d_size = 2'd2; d_wdata = 32'h11111111; ram_busy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("dwr_busy_nowen", {31'h0, ram_wen}, 32'h0);
    check("dwr_busy_addr", ram_addr, 32'h10);
    nRst = 1'b0;
    #1;
    check("rst_mid_ctrl", {28'h0, i_ack, d_ack, d_err, ram_wen}, 32'h0);
    check("rst_mid_addr", ram_addr, 32'h0);
    check("rst_mid_wdata", ram_wdata, 32'h0);
    check("rst_mid_rdata", i_rdata | d_rdata, 32'h0);
    ram_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_wen", {31'h0, ram_wen}, 32'h0);
    check("rst_mid_mem", mem[4], saved);
    check("rst_mid_nwrite", 32'(n_wen - wen0), 32'd0);
    d_wen = 1'b0;
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
